imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader and the write-side counterpart of the instruction memory. It accepts a length-prefixed little-endian byte stream over a valid/ready interface and writes each byte into the instruction memory's byte write port, starting at the reset vector 0xBFC00000. It holds the core in reset until the image is fully committed, then releases it. It sits between the host byte link (UART receiver) and the instruction memory.

## Interface
- BASE_ADDR, 32'hBFC00000, absolute address of the first image byte.
- MEM_BYTES, 4096, capacity in bytes; the maximum legal image length.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- rx_valid  in  1  stream byte valid
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts a byte; combinational from state only
- mem_we  out  1  byte write strobe to the instruction memory
- mem_addr  out  32  absolute byte address, BASE_ADDR + offset
- mem_wdata  out  8  byte to write
- cpu_rst_n  out  1  active-low core reset; low while a load is pending or in progress
- busy  out  1  high in any receive state
- done  out  1  sticky; image committed
- error  out  1  sticky; load aborted
- bytes_loaded  out  13  payload bytes written so far

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit byte count N, little-endian), then N payload bytes, then one checksum byte if IMEM_LOADER_CHECKSUM_EN is defined.
- States: IDLE -> LEN_LO -> LEN_HI -> DATA -> [CHK] -> DONE; any receive state may go -> ERR.
- IDLE: on start, go to LEN_LO, clear done, error and bytes_loaded, and drive cpu_rst_n low.
- LEN_HI accept: if N == 0 or N > MEM_BYTES, go to ERR. Otherwise go to DATA with offset = 0.
- DATA: each accepted byte produces one write at BASE_ADDR + offset, then offset and bytes_loaded increment. After the Nth byte, go to CHK (macro defined) or DONE.
- Byte order in memory equals stream order, so a little-endian word stream is fetched correctly by a PC-aligned 4-byte read.
- Offset never wraps; the length check bounds it to MEM_BYTES-1.
- DONE and ERR: rx_ready = 0. start restarts the sequence. Other input is ignored; rx_valid bytes are not consumed.
- start while busy is ignored.
- cpu_rst_n rises only in DONE. It stays low in ERR.

## Timing
- Reset values: state IDLE, rx_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, cpu_rst_n 0, busy 0, done 0, error 0, bytes_loaded 0.
- Handshake: a transfer occurs on a rising edge with rx_valid & rx_ready. rx_ready is 1 in LEN_LO, LEN_HI, DATA and CHK. Throughput is one byte per cycle; gaps in rx_valid are allowed.
- Write latency: the byte accepted at edge k appears on mem_we/mem_addr/mem_wdata (all registered) for exactly the cycle k..k+1. The memory commits it at edge k+1.
- Release: cpu_rst_n rises at the edge after DONE is entered, so the first core fetch follows the final write commit.
- done and error are registered and assert in the cycle the state becomes DONE or ERR.
- Reset mid-load: all state clears asynchronously, the in-flight write strobe drops immediately, and the partial image is left in memory with cpu_rst_n low.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: a CHK state follows DATA and accepts one byte. If it equals the XOR of all payload bytes, go to DONE; otherwise go to ERR. The payload has already been written either way.
- IMEM_LOADER_CHECKSUM_EN undefined: there is no CHK state and DATA goes directly to DONE.

## Structure
- Shared package imem_pkg holds:
  - the loader_state_t enum (IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR);
  - IMEM_BASE = 32'hBFC00000 and IMEM_BYTES = 4096, also used by the instruction memory's address decode.
- No sub-module: a single FSM plus offset/length counters.

## Test plan
- Reset: assert rst_n = 0 mid-cycle -> all outputs at the reset values listed under Timing, asynchronously.
- Normal load: start, then stream 04 00 13 00 00 00 -> four writes at BFC00000..BFC00003 with data 13,00,00,00, bytes_loaded = 4, done = 1, cpu_rst_n high one cycle after the last mem_we.
- Bad lengths: header 00 00 -> error = 1 with no writes. Header 01 10 (4097) -> error = 1, cpu_rst_n stays 0, rx_ready = 0.
- Gappy stream: an 8-byte image with rx_valid toggling every other cycle -> contiguous addresses BFC00000..BFC00007, no dropped or duplicated writes.
- Checksum (macro defined): payload AA 55 with checksum FF -> done. The same payload with checksum 00 -> error = 1 after both writes, cpu_rst_n stays 0. A later start followed by a valid stream reloads and reaches done.
- Reset mid-load: drive rst_n = 0 after 2 of 8 payload bytes -> IDLE, mem_we 0, cpu_rst_n 0. A subsequent full load completes normally.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared instruction-memory constants and the boot loader state type.
// Used by imem_loader and by the instruction memory address decode.
package imem_pkg;

    localparam logic [31:0] IMEM_BASE  = 32'hBFC00000;
    localparam int          IMEM_BYTES = 4096;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream into imem, core held in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = IMEM_BASE,
    parameter int          MEM_BYTES = IMEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [12:0] bytes_loaded
);

    localparam int OW = $clog2(MEM_BYTES);

    loader_state_t state;
    loader_state_t state_nx;

    logic [7:0]    len_lo;
    logic [15:0]   len;
    logic [OW-1:0] offset;
    logic [15:0]   n_hdr;
    logic          len_bad;
    logic          last_byte;
    logic          xfer;
    logic          restart;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    assign n_hdr     = {rx_data, len_lo};
    assign len_bad   = (n_hdr == 16'd0) || (int'(n_hdr) > MEM_BYTES);
    assign last_byte = ({{(16-OW){1'b0}}, offset} == len - 16'd1);
    assign xfer      = rx_valid & rx_ready;
    assign restart   = (state_nx == LEN_LO) && (state != LEN_LO);

    always_comb begin
        rx_ready = 1'b0;
        unique case (state)
            LEN_LO, LEN_HI, DATA, CHK: rx_ready = 1'b1;
            default:                   rx_ready = 1'b0;
        endcase
    end

    assign busy = rx_ready;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) state_nx = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) state_nx = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) state_nx = len_bad ? ERR : DATA;
            end
            DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer && last_byte) state_nx = CHK;
`else
                if (xfer && last_byte) state_nx = DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) state_nx = (rx_data == csum) ? DONE : ERR;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo       <= '0;
            len          <= '0;
            offset       <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            cpu_rst_n    <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            bytes_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            mem_we    <= 1'b0;
            // release one edge after DONE so the last write commits first
            cpu_rst_n <= (state == DONE) && (state_nx == DONE);
            if (restart) begin
                done         <= 1'b0;
                error        <= 1'b0;
                bytes_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum         <= '0;
`endif
            end
            if (state_nx == DONE && state != DONE) done  <= 1'b1;
            if (state_nx == ERR  && state != ERR)  error <= 1'b1;
            if (xfer && state == LEN_LO) len_lo <= rx_data;
            if (xfer && state == LEN_HI) begin
                len    <= n_hdr;
                offset <= '0;
            end
            if (xfer && state == DATA) begin
                mem_we       <= 1'b1;
                mem_addr     <= BASE_ADDR + 32'(offset);
                mem_wdata    <= rx_data;
                bytes_loaded <= bytes_loaded + 13'd1;
                if (!last_byte) offset <= offset + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum         <= csum ^ rx_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, hand sequences, random loads.
// Works with or without IMEM_LOADER_CHECKSUM_EN defined.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'hBFC00000;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] bytes_loaded;

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_rst_n    (cpu_rst_n),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bytes_loaded (bytes_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    logic [39:0] wq[$];
    logic [7:0]  pay[$];

    always @(negedge clk) begin
        if (rst_n && mem_we) wq.push_back({mem_addr, mem_wdata});
    end

    typedef struct {
        logic [15:0] len;
        logic [7:0]  pl[8];
        bit          gappy;
        bit          bad_chk;
        bit          exp_done;
        bit          exp_err;
        int          exp_bl;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        if (gap) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 20; t++) begin
            if (rx_ready) begin
                @(negedge clk);
                rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        n_total++;
        $display("FAIL send_timeout: rx_ready never seen for byte %h", b);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input string nm, input logic [15:0] n,
                            input bit gappy, input bit bad_chk,
                            input bit exp_done, input bit exp_err,
                            input int exp_bl, input int mid_start);
        logic [7:0] x;
        int         m;
        wq.delete();
        x = 8'h00;
        pulse_start();
        check({nm, ":start_busy"}, 32'(busy), 32'd1);
        check({nm, ":start_cpurst"}, 32'(cpu_rst_n), 32'd0);
        check({nm, ":start_clr"}, {17'd0, done, error, bytes_loaded}, 32'd0);
        send(n[7:0], gappy);
        send(n[15:8], gappy);
        if (exp_bl != 0) begin
            for (int i = 0; i < int'(n); i++) begin
                if (i == mid_start) start = 1'b1;
                send(pay[i], gappy);
                start = 1'b0;
                x = x ^ pay[i];
            end
            if (CHK_EN) send(bad_chk ? ~x : x, gappy);
        end
        check({nm, ":done_now"}, 32'(done), 32'(exp_done));
        check({nm, ":err_now"}, 32'(error), 32'(exp_err));
        check({nm, ":cpurst_hold"}, 32'(cpu_rst_n), 32'd0);
        @(negedge clk);
        check({nm, ":cpurst_after"}, 32'(cpu_rst_n), 32'(exp_done));
        check({nm, ":rx_ready"}, 32'(rx_ready), 32'd0);
        check({nm, ":busy"}, 32'(busy), 32'd0);
        check({nm, ":mem_we"}, 32'(mem_we), 32'd0);
        check({nm, ":bytes_loaded"}, 32'(bytes_loaded), 32'(exp_bl));
        check({nm, ":n_writes"}, 32'(wq.size()), 32'(exp_bl));
        m = 0;
        for (int i = 0; i < wq.size() && i < exp_bl; i++) begin
            if (wq[i] !== {BASE + 32'(i), pay[i]}) m++;
        end
        check({nm, ":wr_content"}, 32'(m), 32'd0);
    endtask

    task automatic load_vec(input vec_t v, input string nm);
        pay.delete();
        for (int i = 0; i < int'(v.len); i++)
            pay.push_back(i < 8 ? v.pl[i] : (8'(i) ^ 8'h5A));
        run_load(nm, v.len, v.gappy, v.bad_chk, v.exp_done, v.exp_err,
                 v.exp_bl, -1);
    endtask

    initial begin
        logic [15:0] n;
        bit          valid;
        bit          bad;
        bit          gap;
        int          cat;

        n_pass   = 0;
        n_total  = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        tbl[0] = '{16'd4, '{8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   1'b0, 1'b0, 1'b1, 1'b0, 4};
        tbl[1] = '{16'd0, '{8{8'h00}}, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[2] = '{16'h1001, '{8{8'h00}}, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[3] = '{16'd8, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88},
                   1'b1, 1'b0, 1'b1, 1'b0, 8};
        tbl[4] = '{16'd2, '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   1'b0, 1'b0, 1'b1, 1'b0, 2};
        tbl[5] = '{16'd2, '{8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   1'b0, 1'b1, !CHK_EN, CHK_EN, 2};
        tbl[6] = '{16'd4096, '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04},
                   1'b0, 1'b0, 1'b1, 1'b0, 4096};
        tbl[7] = '{16'd1, '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   1'b1, 1'b0, 1'b1, 1'b0, 1};

        repeat (2) @(negedge clk);
        check("rst:rx_ready", 32'(rx_ready), 32'd0);
        check("rst:mem_we", 32'(mem_we), 32'd0);
        check("rst:mem_addr", mem_addr, BASE);
        check("rst:mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst:cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst:flags", {17'd0, busy, done, error, bytes_loaded}, 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) load_vec(tbl[k], $sformatf("vec%0d", k));

        // start pulse while a load is running must not disturb it
        pay.delete();
        for (int i = 0; i < 8; i++) pay.push_back(8'(8'hC0 + i));
        run_load("start_busy", 16'd8, 1'b0, 1'b0, 1'b1, 1'b0, 8, 3);

        // reset in the middle of a load, during a write cycle
        wq.delete();
        pay.delete();
        for (int i = 0; i < 8; i++) pay.push_back(8'(8'h30 + i));
        pulse_start();
        send(8'd8, 1'b0);
        send(8'd0, 1'b0);
        send(pay[0], 1'b0);
        send(pay[1], 1'b0);
        check("midrst:we_before", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst:mem_we", 32'(mem_we), 32'd0);
        check("midrst:cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("midrst:mem_addr", mem_addr, BASE);
        check("midrst:flags", {16'd0, rx_ready, busy, done, error, bytes_loaded}, 32'd0);
        check("midrst:partial", 32'(wq.size()), 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        run_load("after_rst", 16'd8, 1'b0, 1'b0, 1'b1, 1'b0, 8, -1);

        for (int r = 0; r < 24; r++) begin
            cat = int'($urandom_range(0, 9));
            if (cat == 0)      n = 16'd0;
            else if (cat == 1) n = 16'(4097 + $urandom_range(0, 60000));
            else               n = 16'($urandom_range(1, 48));
            gap = 1'($urandom % 2);
            bad = 1'($urandom % 2);
            pay.delete();
            for (int i = 0; i < 48; i++) pay.push_back(8'($urandom));
            valid = (n != 16'd0) && (int'(n) <= 4096);
            run_load($sformatf("rnd%0d", r), n, gap, bad,
                     valid && !(CHK_EN && bad),
                     !(valid && !(CHK_EN && bad)),
                     valid ? int'(n) : 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
